// File: rtl/vx_hw_itr_ctrl_pkg.sv
// Shared constants, CSR offsets and delivery states for the per-core hardware interrupt controller.
package vx_hw_itr_ctrl_pkg;

  localparam int NUM_WARPS     = 4;
  localparam int NW_BITS       = 2;
  localparam int UUID_WIDTH    = 44;
  localparam int CSR_ADDR_BITS = 12;
  localparam int CAUSE_W       = 5;

  localparam logic [CSR_ADDR_BITS-1:0] HW_ITR_CTRL_BEGIN = 12'hBC0;
  localparam logic [CSR_ADDR_BITS-1:0] HW_ITR_CTRL_END   = 12'hBD0;

  localparam logic [3:0] OFF_PENDING   = 4'd0;
  localparam logic [3:0] OFF_ENABLE    = 4'd1;
  localparam logic [3:0] OFF_ROUTE_SEL = 4'd2;
  localparam logic [3:0] OFF_ROUTE     = 4'd3;
  localparam logic [3:0] OFF_CAUSE     = 4'd4;
  localparam logic [3:0] OFF_ACK       = 4'd5;
  localparam logic [3:0] OFF_SWI       = 4'd6;
  localparam logic [3:0] OFF_COUNT     = 4'd7;
  localparam logic [3:0] OFF_TIMER     = 4'd8;

  typedef enum logic [1:0] {
    ITR_IDLE     = 2'd0,
    ITR_REQ      = 2'd1,
    ITR_WAIT_ACK = 2'd2
  } itr_state_e;

  // Index of the lowest set bit; scanning downward leaves the smallest index last.
  function automatic logic [CAUSE_W-1:0] lowest_set(input logic [31:0] vec);
    logic [CAUSE_W-1:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = CAUSE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vx_hw_itr_ctrl_sync_edge.sv
// Two-flop synchronizer for asynchronous interrupt lines followed by a rising-edge detector.
module vx_hw_itr_ctrl_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q, sync_q, prev_q;

  // synchronizer chain plus one delayed copy of the synchronized level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/vx_hw_itr_ctrl.sv
// Per-core hardware interrupt controller: CSR-mapped pending/enable/route state and a one-at-a-time
// delivery handshake to the warp scheduler. Define VX_HW_ITR_TIMER_EN to add the countdown timer source.
module vx_hw_itr_ctrl
  import vx_hw_itr_ctrl_pkg::*;
#(
  parameter int NUM_IRQ   = 8,
  parameter int WARP_CNT  = NUM_WARPS,
  parameter int LANES     = 4,
  parameter int PID_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read_enable,
  input  logic [UUID_WIDTH-1:0]    read_uuid,
  input  logic [PID_WIDTH-1:0]     read_pid,
  input  logic [NW_BITS-1:0]       read_wid,
  input  logic [LANES-1:0]         read_tmask,
  input  logic [CSR_ADDR_BITS-1:0] read_addr,
  output logic [LANES*32-1:0]      read_data,
  input  logic                     write_enable,
  input  logic [UUID_WIDTH-1:0]    write_uuid,
  input  logic [PID_WIDTH-1:0]     write_pid,
  input  logic [NW_BITS-1:0]       write_wid,
  input  logic [LANES-1:0]         write_tmask,
  input  logic [CSR_ADDR_BITS-1:0] write_addr,
  input  logic [LANES*32-1:0]      write_data,
  input  logic [NUM_IRQ-1:0]       irq_in,
  output logic                     itr_valid,
  output logic [NW_BITS-1:0]       itr_wid,
  output logic [CAUSE_W-1:0]       itr_cause,
  input  logic                     itr_ready
);

`ifdef VX_HW_ITR_TIMER_EN
  localparam int NSRC = NUM_IRQ + 1;
`else
  localparam int NSRC = NUM_IRQ;
`endif

  itr_state_e                   state_q, state_d;
  logic [NSRC-1:0]              pending_q, pending_d, enable_q, enable_d;
  logic [NSRC-1:0]              clr_s, set_s, src_set_s;
  logic [NSRC-1:0][NW_BITS-1:0] route_q, route_d;
  logic [CAUSE_W-1:0]           route_sel_q, route_sel_d, cause_q, cause_d, pick_s;
  logic [NW_BITS-1:0]           wid_q, wid_d, route_rd_s;
  logic [31:0]                  count_q, count_d, rd_val_s, timer_val_s;
  logic [NUM_IRQ-1:0]           rise_s;
  logic [3:0]                   rd_off_s, wr_off_s;
  logic                         rd_hit_s, wr_hit_s, ack_s;
  logic                         unused_s;

  vx_hw_itr_ctrl_sync_edge #(.WIDTH(NUM_IRQ)) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .async_i (irq_in),
    .rise_o  (rise_s)
  );

  assign rd_hit_s = read_enable && (read_addr >= HW_ITR_CTRL_BEGIN) && (read_addr < HW_ITR_CTRL_END);
  assign wr_hit_s = write_enable && (write_addr >= HW_ITR_CTRL_BEGIN) && (write_addr < HW_ITR_CTRL_END);
  assign rd_off_s = 4'(read_addr - HW_ITR_CTRL_BEGIN);
  assign wr_off_s = 4'(write_addr - HW_ITR_CTRL_BEGIN);
  assign ack_s    = wr_hit_s && (wr_off_s == OFF_ACK) && (write_wid == wid_q);
  assign pick_s   = lowest_set(32'(pending_q & enable_q));

`ifdef VX_HW_ITR_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic        timer_wr_s, timer_fire_s;

  assign timer_wr_s   = wr_hit_s && (wr_off_s == OFF_TIMER);
  assign timer_fire_s = (timer_q == 32'd1) && !timer_wr_s;
  assign timer_val_s  = timer_q;
  assign src_set_s    = {timer_fire_s, rise_s};

  // a load wins over the countdown; zero is the parked (disabled) value
  always_comb begin
    if (timer_wr_s) begin
      timer_d = write_data[31:0];
    end else if (timer_q != 32'd0) begin
      timer_d = timer_q - 32'd1;
    end else begin
      timer_d = timer_q;
    end
  end

  // timer counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= 32'd0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign src_set_s   = rise_s;
  assign timer_val_s = 32'd0;
`endif

  // CSR writes and pending bookkeeping; a new set beats the delivery clear on the same bit
  always_comb begin
    enable_d    = enable_q;
    route_sel_d = route_sel_q;
    route_d     = route_q;
    set_s       = src_set_s;
    if (wr_hit_s) begin
      case (wr_off_s)
        OFF_ENABLE:    enable_d    = write_data[NSRC-1:0];
        OFF_ROUTE_SEL: route_sel_d = write_data[CAUSE_W-1:0];
        OFF_ROUTE: begin
          for (int k = 0; k < NSRC; k++) begin
            if (route_sel_q == CAUSE_W'(k)) route_d[k] = write_data[NW_BITS-1:0];
            else                            route_d[k] = route_q[k];
          end
        end
        OFF_SWI: begin
          for (int k = 0; k < NUM_IRQ; k++) begin
            if (write_data[CAUSE_W-1:0] == CAUSE_W'(k)) set_s[k] = 1'b1;
            else                                        set_s[k] = src_set_s[k];
          end
        end
        default: enable_d = enable_q;
      endcase
    end else begin
      enable_d = enable_q;
    end
    pending_d = (pending_q & ~clr_s) | set_s;
  end

  // delivery FSM next state: pick lowest enabled pending source, handshake, wait for ACK
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    wid_d   = wid_q;
    count_d = count_q;
    clr_s   = '0;
    case (state_q)
      ITR_IDLE: begin
        if (|(pending_q & enable_q)) begin
          cause_d = pick_s;
          for (int k = 0; k < NSRC; k++) begin
            if (pick_s == CAUSE_W'(k)) begin
              wid_d    = route_q[k];
              clr_s[k] = 1'b1;
            end else begin
              clr_s[k] = 1'b0;
            end
          end
          state_d = ITR_REQ;
        end else begin
          state_d = ITR_IDLE;
        end
      end
      ITR_REQ: begin
        if (itr_ready) state_d = ITR_WAIT_ACK;
        else           state_d = ITR_REQ;
      end
      ITR_WAIT_ACK: begin
        if (ack_s) begin
          state_d = ITR_IDLE;
          count_d = count_q + 32'd1;
        end else begin
          state_d = ITR_WAIT_ACK;
        end
      end
      default: state_d = ITR_IDLE;
    endcase
  end

  // controller state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ITR_IDLE;
      pending_q   <= '0;
      enable_q    <= '0;
      route_q     <= '0;
      route_sel_q <= 5'd0;
      cause_q     <= 5'd0;
      wid_q       <= '0;
      count_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      route_q     <= route_d;
      route_sel_q <= route_sel_d;
      cause_q     <= cause_d;
      wid_q       <= wid_d;
      count_q     <= count_d;
    end
  end

  assign itr_valid = (state_q == ITR_REQ);
  assign itr_wid   = wid_q;
  assign itr_cause = cause_q;

  // read mux on pre-write state; CAUSE is private to the warp being interrupted
  always_comb begin
    route_rd_s = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (route_sel_q == CAUSE_W'(k)) route_rd_s = route_q[k];
      else                            route_rd_s = route_rd_s;
    end
    if (rd_hit_s) begin
      case (rd_off_s)
        OFF_PENDING:   rd_val_s = 32'(pending_q);
        OFF_ENABLE:    rd_val_s = 32'(enable_q);
        OFF_ROUTE_SEL: rd_val_s = 32'(route_sel_q);
        OFF_ROUTE:     rd_val_s = 32'(route_rd_s);
        OFF_CAUSE: begin
          if ((state_q != ITR_IDLE) && (read_wid == wid_q)) rd_val_s = {1'b1, 26'd0, cause_q};
          else                                              rd_val_s = 32'd0;
        end
        OFF_COUNT:     rd_val_s = count_q;
        OFF_TIMER:     rd_val_s = timer_val_s;
        default:       rd_val_s = 32'd0;
      endcase
    end else begin
      rd_val_s = 32'd0;
    end
  end

  // replicate the read value onto the active lanes only
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (read_tmask[i]) read_data[i*32 +: 32] = rd_val_s;
      else               read_data[i*32 +: 32] = 32'd0;
    end
  end

  assign unused_s = ^{read_uuid, read_pid, write_uuid, write_pid, write_tmask, write_data, 32'(WARP_CNT)};

endmodule

// File: tb/tb_vx_hw_itr_ctrl.sv
// Self-checking bench for vx_hw_itr_ctrl: directed scenarios plus randomized CSR/IRQ traffic,
// all compared against a transaction-level model of pending bits, deliveries and the register map.
`timescale 1ns/1ps
module tb_vx_hw_itr_ctrl;
  import vx_hw_itr_ctrl_pkg::*;

  localparam int NIRQ = 8;
  localparam int LN   = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     read_enable, write_enable, itr_valid, itr_ready;
  logic [UUID_WIDTH-1:0]    read_uuid, write_uuid;
  logic [0:0]               read_pid, write_pid;
  logic [NW_BITS-1:0]       read_wid, write_wid, itr_wid;
  logic [LN-1:0]            read_tmask, write_tmask;
  logic [CSR_ADDR_BITS-1:0] read_addr, write_addr;
  logic [LN*32-1:0]         read_data, write_data;
  logic [NIRQ-1:0]          irq_in;
  logic [4:0]               itr_cause;

  vx_hw_itr_ctrl #(.NUM_IRQ(NIRQ), .WARP_CNT(4), .LANES(LN), .PID_WIDTH(1)) dut (
    .clk(clk), .reset(reset),
    .read_enable(read_enable), .read_uuid(read_uuid), .read_pid(read_pid), .read_wid(read_wid),
    .read_tmask(read_tmask), .read_addr(read_addr), .read_data(read_data),
    .write_enable(write_enable), .write_uuid(write_uuid), .write_pid(write_pid), .write_wid(write_wid),
    .write_tmask(write_tmask), .write_addr(write_addr), .write_data(write_data),
    .irq_in(irq_in), .itr_valid(itr_valid), .itr_wid(itr_wid), .itr_cause(itr_cause), .itr_ready(itr_ready)
  );

  always #5 clk = ~clk;

  // reference model
  logic [31:0]     m_pend, m_en, m_count;
  int              m_sel, m_cause, m_wid;
  int              m_route [NIRQ];
  bit              m_busy, m_taken;
  logic [NIRQ-1:0] h0, h1, h2;
  int              n_tests = 0;
  int              n_fail  = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pend = 32'd0; m_en = 32'd0; m_count = 32'd0;
    m_sel = 0; m_cause = 0; m_wid = 0; m_busy = 1'b0; m_taken = 1'b0;
    for (int k = 0; k < NIRQ; k++) m_route[k] = 0;
    h0 = '0; h1 = '0; h2 = '0;
  endfunction

  function automatic logic [31:0] exp_word(int off, int wid);
    case (off)
      0: return m_pend;
      1: return m_en;
      2: return 32'(m_sel);
      3: if (m_sel < NIRQ) return 32'(m_route[m_sel]); else return 32'd0;
      4: if (m_busy && wid == m_wid) return 32'h8000_0000 | 32'(m_cause); else return 32'd0;
      7: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [127:0] exp_read();
    logic [127:0] r;
    logic [31:0]  w;
    r = '0;
    if (read_enable && read_addr >= HW_ITR_CTRL_BEGIN && read_addr < HW_ITR_CTRL_END) begin
      w = exp_word(int'(read_addr - HW_ITR_CTRL_BEGIN), int'(read_wid));
      for (int i = 0; i < LN; i++) if (read_tmask[i]) r[i*32 +: 32] = w;
    end
    return r;
  endfunction

  // one clock edge of the model, using the inputs presented during the ending cycle
  function automatic void model_edge();
    logic [31:0] set_v, clr_v;
    int          woff, idx;
    bit          wr_ok;
    wr_ok = write_enable && write_addr >= HW_ITR_CTRL_BEGIN && write_addr < HW_ITR_CTRL_END;
    woff  = int'(write_addr - HW_ITR_CTRL_BEGIN);
    idx   = int'(write_data[4:0]);
    set_v = 32'(h1 & ~h2);
    clr_v = 32'd0;
    if (wr_ok && woff == 6 && idx < NIRQ) set_v[idx] = 1'b1;
    if (!m_busy) begin
      if ((m_pend & m_en) != 32'd0) begin
        for (int k = NIRQ-1; k >= 0; k--) if (m_pend[k] && m_en[k]) m_cause = k;
        m_wid = m_route[m_cause];
        clr_v[m_cause] = 1'b1;
        m_busy = 1'b1; m_taken = 1'b0;
      end
    end else if (!m_taken) begin
      if (itr_ready) m_taken = 1'b1;
    end else if (wr_ok && woff == 5 && int'(write_wid) == m_wid) begin
      m_busy = 1'b0;
      m_count = m_count + 32'd1;
    end
    m_pend = (m_pend & ~clr_v) | set_v;
    if (wr_ok && woff == 1) m_en = 32'(write_data[NIRQ-1:0]);
    if (wr_ok && woff == 2) m_sel = idx;
    if (wr_ok && woff == 3 && m_sel < NIRQ) m_route[m_sel] = int'(write_data[1:0]);
    h2 = h1; h1 = h0; h0 = irq_in;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
    check("itr_valid", 128'(itr_valid), 128'(m_busy && !m_taken));
    if (m_busy && !m_taken) begin
      check("itr_wid", 128'(itr_wid), 128'(m_wid));
      check("itr_cause", 128'(itr_cause), 128'(m_cause));
    end
    check("read_data", read_data, exp_read());
  endtask

  task automatic wr(int off, logic [31:0] d, logic [1:0] wid);
    write_enable = 1'b1;
    write_addr   = HW_ITR_CTRL_BEGIN + 12'(off);
    write_data   = {96'd0, d};
    write_wid    = wid;
    step();
    write_enable = 1'b0;
  endtask

  task automatic rd(int off, logic [1:0] wid, logic [3:0] tm, output logic [127:0] v);
    read_enable = 1'b1;
    read_addr   = HW_ITR_CTRL_BEGIN + 12'(off);
    read_wid    = wid;
    read_tmask  = tm;
    #1;
    v = read_data;
    check("rd_model", v, exp_read());
  endtask

  task automatic wait_valid(string tag);
    for (int i = 0; i < 20 && itr_valid !== 1'b1; i++) step();
    check({tag, "_timeout"}, 128'(itr_valid), 128'd1);
  endtask

  task automatic deliver_ack(string tag, int cause, logic [1:0] wid);
    wait_valid(tag);
    check({tag, "_cause"}, 128'(itr_cause), 128'(cause));
    check({tag, "_wid"}, 128'(itr_wid), 128'(wid));
    itr_ready = 1'b1;
    step();
    itr_ready = 1'b0;
    wr(5, 32'd0, wid);
  endtask

  logic [127:0] v;
  int           roff, woff;
  logic [31:0]  d;

  initial begin
    reset = 1'b0; read_enable = 1'b0; write_enable = 1'b0; itr_ready = 1'b0; irq_in = '0;
    read_uuid = '0; write_uuid = '0; read_pid = '0; write_pid = '0; read_wid = '0; write_wid = '0;
    read_tmask = '0; write_tmask = 4'hF; read_addr = '0; write_addr = '0; write_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    rd(1, 2'd0, 4'hF, v); check("rst_enable", v, 128'd0);
    check("rst_itr_valid", 128'(itr_valid), 128'd0);

    // single source routed to warp 3, held request, CAUSE read and ACK matching
    wr(1, 32'h04, 2'd0); wr(2, 32'd2, 2'd0); wr(3, 32'd3, 2'd0);
    irq_in = 8'h04; step(); irq_in = '0; step(); step();
    check("t1_not_yet", 128'(itr_valid), 128'd0);
    step();
    check("t1_valid", 128'(itr_valid), 128'd1);
    check("t1_wid", 128'(itr_wid), 128'd3);
    check("t1_cause", 128'(itr_cause), 128'd2);
    repeat (5) begin step(); check("t1_hold_wid", 128'(itr_wid), 128'd3); end
    itr_ready = 1'b1; step(); itr_ready = 1'b0;
    check("t1_accepted", 128'(itr_valid), 128'd0);
    rd(4, 2'd3, 4'b0101, v); check("t1_cause_rd", v, 128'h0000_0000_8000_0002_0000_0000_8000_0002);
    wr(5, 32'd0, 2'd1);
    rd(4, 2'd3, 4'b0101, v); check("t1_bad_ack", v, 128'h0000_0000_8000_0002_0000_0000_8000_0002);
    wr(5, 32'd0, 2'd3);
    rd(7, 2'd0, 4'b0001, v); check("t1_count", v, 128'd1);

    // simultaneous edges: lowest index first
    wr(1, 32'hFF, 2'd0);
    irq_in = 8'h22; step(); irq_in = '0;
    wait_valid("t2a");
    check("t2_first", 128'(itr_cause), 128'd1);
    itr_ready = 1'b1; step(); itr_ready = 1'b0;
    rd(0, 2'd0, 4'b0001, v); check("t2_pend_between", v, 128'h20);
    wr(5, 32'd0, 2'd0);
    deliver_ack("t2b", 5, 2'd0);

    // software interrupt, masked then enabled; out-of-range index ignored
    wr(1, 32'hBF, 2'd0); wr(6, 32'd6, 2'd0);
    rd(0, 2'd0, 4'b0001, v); check("t3_swi_pend", v, 128'h40);
    repeat (3) step();
    check("t3_masked", 128'(itr_valid), 128'd0);
    wr(1, 32'hFF, 2'd0);
    deliver_ack("t3", 6, 2'd0);
    wr(6, 32'd40, 2'd0);
    rd(0, 2'd0, 4'b0001, v); check("t3_swi_40", v, 128'd0);

    // asynchronous reset during a pending request
    wr(6, 32'd3, 2'd0);
    wait_valid("t4");
    #1 reset = 1'b0;
    #1 model_reset();
    check("t4_rst_valid", 128'(itr_valid), 128'd0);
    check("t4_rst_wid", 128'(itr_wid), 128'd0);
    check("t4_rst_cause", 128'(itr_cause), 128'd0);
    read_enable = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    rd(1, 2'd0, 4'hF, v); check("t4_enable", v, 128'd0);
    step();
    rd(0, 2'd0, 4'hF, v); check("t4_pending", v, 128'd0);
    step();
    rd(7, 2'd0, 4'hF, v); check("t4_count", v, 128'd0);
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NIRQ; b++) if ($urandom_range(0, 11) == 0) irq_in[b] = ~irq_in[b];
      itr_ready   = ($urandom_range(0, 2) != 0);
      read_enable = 1'($urandom_range(0, 1));
      roff        = int'($urandom_range(0, 10));
      read_addr   = (roff == 10) ? (HW_ITR_CTRL_BEGIN - 12'd1) : (HW_ITR_CTRL_BEGIN + 12'(roff));
      read_wid    = 2'($urandom_range(0, 3));
      read_tmask  = 4'($urandom_range(0, 15));
      write_enable = ($urandom_range(0, 2) == 0);
      woff        = int'($urandom_range(0, 9));
      write_addr  = (woff == 9) ? HW_ITR_CTRL_END : (HW_ITR_CTRL_BEGIN + 12'(woff));
      case (woff)
        1:       d = $urandom_range(0, 255);
        2:       d = $urandom_range(0, 9);
        6:       d = $urandom_range(0, 40);
        default: d = $urandom;
      endcase
      write_data = {$urandom, $urandom, $urandom, d};
      write_wid  = ($urandom_range(0, 1) != 0) ? 2'(m_wid) : 2'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_hw_itr_ctrl.md
Name: VX_hw_itr_ctrl

Overview:
Per-core hardware interrupt controller. It is the responder (slave) end of the VX_sfu_csr_if bus that the CSR unit drives for addresses in [VX_HW_ITR_CTRL_BEGIN, VX_HW_ITR_CTRL_END).
- Captures external interrupt lines and holds per-source pending/enable state.
- Routes each source to a target warp and delivers one interrupt at a time to the warp scheduler through a valid/ready handshake.
- Delivery completes when software writes the ACK CSR.

Parameters:
NUM_IRQ, 8, number of external interrupt sources (1..32)
WARP_CNT, `NUM_WARPS, warps per core
LANES, 4, lanes on the CSR bus (fixed width of read_data/write_data)
PID_WIDTH, 1, packet-id width on the CSR bus

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
read_enable  in  1  CSR read strobe
read_uuid  in  `UUID_WIDTH  debug tag, unused
read_pid  in  PID_WIDTH  unused
read_wid  in  `NW_BITS  requesting warp
read_tmask  in  LANES  active lanes
read_addr  in  `VX_CSR_ADDR_BITS  CSR address
read_data  out  LANES*32  read response, combinational, same cycle
write_enable  in  1  CSR write strobe
write_uuid  in  `UUID_WIDTH  unused
write_pid  in  PID_WIDTH  unused
write_wid  in  `NW_BITS  writing warp
write_tmask  in  LANES  active lanes
write_addr  in  `VX_CSR_ADDR_BITS  CSR address
write_data  in  LANES*32  write data; only lane 0 is used
irq_in  in  NUM_IRQ  asynchronous external interrupt lines, level-high
itr_valid  out  1  interrupt request to scheduler
itr_wid  out  `NW_BITS  target warp
itr_cause  out  5  source index
itr_ready  in  1  scheduler accepts

Behaviour:
Register map (offset from VX_HW_ITR_CTRL_BEGIN):
- 0 PENDING (RO): NUM_IRQ bits, zero-extended.
- 1 ENABLE (RW): NUM_IRQ bits; reset 0.
- 2 ROUTE_SEL (RW): source index; reset 0.
- 3 ROUTE (RW): target wid of the source selected by ROUTE_SEL; reset 0 for every source.
- 4 CAUSE (RO): {valid bit 31, cause[4:0]} of the in-flight interrupt, returned only if read_wid equals the delivered wid, else 0.
- 5 ACK (WO): any write with write_wid equal to the delivered wid completes delivery.
- 6 SWI (WO): sets pending[write_data[4:0]]. Indices >= NUM_IRQ are ignored.
- 7 COUNT (RO): 32-bit count of delivered interrupts, wraps.
- Other offsets: read 0, write ignored.

Read/write rules:
- read_data lane i = value when read_tmask[i], else 0. Read value is pre-write (old) state.
- Writes commit on the next rising edge.

Input capture:
- irq_in passes through a 2-flop synchronizer, then rising-edge detection. Each edge sets pending[k].
- Set has priority over clear in the same cycle.

Delivery FSM, states IDLE, REQ, WAIT_ACK:
- IDLE: if |(pending & enable), select the lowest index k. Latch cause=k and wid=route[k], clear pending[k], go to REQ.
- REQ: itr_valid=1. itr_wid and itr_cause are held stable until itr_ready, then go to WAIT_ACK.
- WAIT_ACK: a matching ACK write increments COUNT and returns to IDLE. A non-matching ACK is ignored.
- ACK in IDLE or REQ is ignored.

Reset (async assert, sync deassert externally):
- All state clears: FSM=IDLE, itr_valid=0, itr_wid=0, itr_cause=0, read_data=0 when no read.
- Reset mid-delivery drops the in-flight interrupt; its pending bit is not restored.

Optional Feature:
VX_HW_ITR_TIMER_EN
- Defined: adds source index NUM_IRQ (requires NUM_IRQ<=31) driven by a 32-bit down-counter.
  - Offset 8 TIMER (RW) loads the counter.
  - Reaching 0 from 1 sets pending[NUM_IRQ]; the counter stays at 0 until reloaded.
  - Writing 0 disables the timer.
- Undefined: offset 8 reads 0 and writes are ignored; no extra source.

Decomposition:
- VX_gpu_pkg: offset localparams, itr_state_e enum, cause width constant.
- VX_define.vh: VX_HW_ITR_CTRL_BEGIN/END already exist.
- One sub-module: VX_irq_sync_edge (2-flop synchronizer plus rising-edge detector, NUM_IRQ wide). Everything else stays in the top.

Test Plan:
- ENABLE=0x04, ROUTE[2]=3, pulse irq_in[2] -> 3 cycles later itr_valid=1, itr_wid=3, itr_cause=2. Hold itr_ready=0 for 5 cycles -> outputs stable. Then itr_ready=1 -> WAIT_ACK.
- In WAIT_ACK: read CAUSE with wid=3 -> 0x80000002 on lanes in tmask 0b0101. ACK from wid=1 -> no change. ACK from wid=3 -> IDLE, COUNT=1.
- Edges on irq 1 and 5 in the same cycle, ENABLE=0xFF -> irq 1 delivered first, then 5 after its ACK. PENDING reads 0x20 between the two deliveries.
- SWI write data=6 with ENABLE bit 6 clear -> PENDING=0x40, no itr_valid. Set ENABLE bit 6 -> delivery of cause 6. SWI data=40 -> no effect.
- Assert reset during REQ -> itr_valid=0 immediately (async). After release: ENABLE=0, PENDING=0, COUNT=0.
- VX_HW_ITR_TIMER_EN: write TIMER=10, ENABLE bit NUM_IRQ set -> itr_valid with cause=NUM_IRQ after 10 cycles plus delivery latency.
